// File: rtl/temp_avg_controller.sv
// -----------------------------------------------------------------------------
// temp_avg_controller
//
// Sequencer that sits in front of output_display. A start request snapshots
// every sensor reading and enable bit, walks the snapshot one sensor per cycle
// to build the sum of the enabled readings and the number of enabled sensors,
// then runs a 16-step restoring division. The quotient, remainder and sensor
// count are presented together with a one-cycle valid pulse. One average is
// produced per accepted start.
//
// Parameters
//   NR_SENSORS  number of sensors (1..255)
//   DATA_W      width of one unsigned temperature reading
//
// Ports
//   clk_i                single clock, rising edge
//   rst_i                asynchronous, active-high reset
//   start_i              request a new average, honoured only while idle
//   sensors_data_i       reading k at bits [k*DATA_W +: DATA_W]
//   sensors_en_i         bit k set -> sensor k is active
//   busy_o               high while accumulating, dividing or finishing
//   valid_o              one-cycle pulse, result outputs updated this cycle
//   temp_Q_o             sum / count
//   temp_R_o             sum % count
//   active_sensors_nr_o  number of enabled sensors in the snapshot
//   no_sensor_o          last result had no enabled sensor
// -----------------------------------------------------------------------------
module temp_avg_controller #(
  parameter int NR_SENSORS = 100,
  parameter int DATA_W     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [NR_SENSORS*DATA_W-1:0] sensors_data_i,
  input  logic [NR_SENSORS-1:0]        sensors_en_i,
  output logic                         busy_o,
  output logic                         valid_o,
  output logic [15:0]                  temp_Q_o,
  output logic [15:0]                  temp_R_o,
  output logic [7:0]                   active_sensors_nr_o,
  output logic                         no_sensor_o
);

  localparam int IDX_W = (NR_SENSORS > 1) ? $clog2(NR_SENSORS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_SENSORS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIVIDE,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Snapshot of the sensor inputs, consumed from the low end one sensor
  // per cycle so the current reading is always at the bottom.
  logic [NR_SENSORS*DATA_W-1:0] data_snap;
  logic [NR_SENSORS-1:0]        en_snap;

  logic [IDX_W-1:0] index;
  logic [15:0]      sum;
  logic [7:0]       count;

  // Divider: quo starts as the dividend and is shifted left while the
  // quotient bits enter from the right; rem is the partial remainder.
  logic [15:0] quo;
  logic [16:0] rem;
  logic [3:0]  step;

  logic accum_last;
  logic div_last;

  logic snap_load;
  logic accum_en;
  logic div_en;
  logic done_en;

  logic [15:0] sum_next;
  logic [7:0]  count_next;
  logic [16:0] rem_shift;
  logic [16:0] divisor;
  logic        rem_ge;

  assign accum_last = (index == LAST_IDX);
  assign div_last   = (step == 4'd15);

  // Running sum and count including the sensor currently at the bottom of
  // the snapshot.
  always_comb begin
    sum_next   = sum;
    count_next = count;
    if (en_snap[0]) begin
      sum_next   = sum + 16'(data_snap[DATA_W-1:0]);
      count_next = count + 8'd1;
    end
  end

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the divisor if it fits.
  always_comb begin
    rem_shift = 17'({rem, quo[15]});
    divisor   = {9'd0, count};
    rem_ge    = (rem_shift >= divisor);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i)    state_next = ACCUM;
      ACCUM:   if (accum_last) state_next = DIVIDE;
      DIVIDE:  if (div_last)   state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Output and datapath-control decode.
  always_comb begin
    busy_o    = 1'b0;
    snap_load = 1'b0;
    accum_en  = 1'b0;
    div_en    = 1'b0;
    done_en   = 1'b0;
    case (state)
      IDLE:    snap_load = start_i;
      ACCUM: begin
        busy_o   = 1'b1;
        accum_en = 1'b1;
      end
      DIVIDE: begin
        busy_o = 1'b1;
        div_en = 1'b1;
      end
      DONE: begin
        busy_o  = 1'b1;
        done_en = 1'b1;
      end
      default: busy_o = 1'b0;
    endcase
  end

  // Snapshot, accumulation and division datapath.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_snap <= '0;
      en_snap   <= '0;
      index     <= '0;
      sum       <= '0;
      count     <= '0;
      quo       <= '0;
      rem       <= '0;
      step      <= '0;
    end else begin
      if (snap_load) begin
        data_snap <= sensors_data_i;
        en_snap   <= sensors_en_i;
        index     <= '0;
        sum       <= '0;
        count     <= '0;
      end
      if (accum_en) begin
        data_snap <= data_snap >> DATA_W;
        en_snap   <= en_snap >> 1;
        index     <= index + 1'b1;
        sum       <= sum_next;
        count     <= count_next;
        // The final sum is loaded straight into the divider so the first
        // division step can run on the very next cycle.
        if (accum_last) begin
          quo  <= sum_next;
          rem  <= '0;
          step <= '0;
        end
      end
      if (div_en) begin
        step <= step + 4'd1;
        if (rem_ge) begin
          rem <= rem_shift - divisor;
          quo <= {quo[14:0], 1'b1};
        end else begin
          rem <= rem_shift;
          quo <= {quo[14:0], 1'b0};
        end
      end
    end
  end

  // Result registers. With no enabled sensor the divider ran against zero
  // and produced meaningless bits, so the result is forced to zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o             <= 1'b0;
      temp_Q_o            <= '0;
      temp_R_o            <= '0;
      active_sensors_nr_o <= '0;
      no_sensor_o         <= 1'b0;
    end else begin
      valid_o <= done_en;
      if (done_en) begin
        active_sensors_nr_o <= count;
        no_sensor_o         <= (count == 8'd0);
        if (count == 8'd0) begin
          temp_Q_o <= '0;
          temp_R_o <= '0;
        end else begin
          temp_Q_o <= quo;
          temp_R_o <= rem[15:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_temp_avg_controller.sv
// -----------------------------------------------------------------------------
// tb_temp_avg_controller
//
// Self-checking bench for temp_avg_controller. A 4-sensor instance covers the
// directed cases, ignored start requests, mid-run input changes, reset during
// division and randomized runs; a 100-sensor instance covers full-scale sums
// and the long latency. Expected results come from a plain arithmetic model
// of the average over the enabled readings.
// -----------------------------------------------------------------------------
module tb_temp_avg_controller;

  logic clk = 1'b0;
  logic rst;

  logic        start4;
  logic [31:0] data4;
  logic [3:0]  en4;
  logic        busy4, valid4, noSensor4;
  logic [15:0] q4, r4;
  logic [7:0]  nr4;

  logic         start100;
  logic [799:0] data100;
  logic [99:0]  en100;
  logic         busy100, valid100, noSensor100;
  logic [15:0]  q100, r100;
  logic [7:0]   nr100;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  temp_avg_controller #(.NR_SENSORS(4), .DATA_W(8)) dut4 (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start4),
    .sensors_data_i      (data4),
    .sensors_en_i        (en4),
    .busy_o              (busy4),
    .valid_o             (valid4),
    .temp_Q_o            (q4),
    .temp_R_o            (r4),
    .active_sensors_nr_o (nr4),
    .no_sensor_o         (noSensor4)
  );

  temp_avg_controller #(.NR_SENSORS(100), .DATA_W(8)) dut100 (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start100),
    .sensors_data_i      (data100),
    .sensors_en_i        (en100),
    .busy_o              (busy100),
    .valid_o             (valid100),
    .temp_Q_o            (q100),
    .temp_R_o            (r100),
    .active_sensors_nr_o (nr100),
    .no_sensor_o         (noSensor100)
  );

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: average of the enabled readings as plain integer arithmetic.
  function automatic void modelAverage(input logic [799:0] data, input logic [99:0] en,
                                       input int nr, output int q, output int r,
                                       output int cnt);
    int sum;
    sum = 0;
    cnt = 0;
    for (int k = 0; k < nr; k++) begin
      if (en[k]) begin
        sum += int'(data[k*8 +: 8]);
        cnt++;
      end
    end
    if (cnt == 0) begin
      q = 0;
      r = 0;
    end else begin
      q = sum / cnt;
      r = sum % cnt;
    end
  endfunction

  // One full run on the 4-sensor instance. With perturb set, start is pulsed
  // during accumulation and during the final cycle, and the inputs change
  // after the snapshot.
  task automatic applyStimulus(input string tag, input logic [31:0] data,
                               input logic [3:0] en, input bit perturb);
    int q, r, cnt, n, extra;
    bit seen;
    modelAverage({768'd0, data}, {96'd0, en}, 4, q, r, cnt);
    @(negedge clk);
    data4  = data;
    en4    = en;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    checkOutput({tag, " busy"}, busy4, 1);
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (valid4) begin
        seen = 1;
      end else if (perturb) begin
        if (n == 2) begin
          start4 = 1'b1;
          data4  = $urandom;
          en4    = 4'($urandom);
        end
        if (n == 3) start4 = 1'b0;
        if (n == 20) start4 = 1'b1;
      end
    end
    start4 = 1'b0;
    checkOutput({tag, " latency"}, n, 21);
    checkOutput({tag, " Q"}, q4, q);
    checkOutput({tag, " R"}, r4, r);
    checkOutput({tag, " nr"}, nr4, cnt);
    checkOutput({tag, " no_sensor"}, noSensor4, (cnt == 0));
    checkOutput({tag, " busy after"}, busy4, 0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (valid4 || busy4) extra++;
    end
    checkOutput({tag, " single pulse"}, extra, 0);
    checkOutput({tag, " Q held"}, q4, q);
  endtask

  // One full run on the 100-sensor instance.
  task automatic applyStimulus100(input string tag, input logic [799:0] data,
                                  input logic [99:0] en);
    int q, r, cnt, n;
    bit seen;
    modelAverage(data, en, 100, q, r, cnt);
    @(negedge clk);
    data100  = data;
    en100    = en;
    start100 = 1'b1;
    @(posedge clk);
    #1;
    start100 = 1'b0;
    n    = 0;
    seen = 0;
    while (!seen && n < 150) begin
      @(posedge clk);
      #1;
      n++;
      if (valid100) seen = 1;
    end
    checkOutput({tag, " latency"}, n, 117);
    checkOutput({tag, " Q"}, q100, q);
    checkOutput({tag, " R"}, r100, r);
    checkOutput({tag, " nr"}, nr100, cnt);
    checkOutput({tag, " no_sensor"}, noSensor100, (cnt == 0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [799:0] bigData;
    logic [99:0]  bigEn;
    int           extra;

    rst      = 1'b1;
    start4   = 1'b0;
    data4    = '0;
    en4      = '0;
    start100 = 1'b0;
    data100  = '0;
    en100    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset valid", valid4, 0);
    checkOutput("reset busy", busy4, 0);
    checkOutput("reset Q", q4, 0);
    checkOutput("reset R", r4, 0);
    checkOutput("reset nr", nr4, 0);
    checkOutput("reset no_sensor", noSensor4, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("all4", {8'd23, 8'd22, 8'd21, 8'd20}, 4'b1111, 0);
    applyStimulus("two", {8'd0, 8'd25, 8'd0, 8'd30}, 4'b0101, 0);
    applyStimulus("none", {8'd9, 8'd8, 8'd7, 8'd6}, 4'b0000, 0);
    applyStimulus("perturb", {8'd23, 8'd22, 8'd21, 8'd20}, 4'b1111, 1);
    applyStimulus("max", {8'd255, 8'd255, 8'd255, 8'd255}, 4'b1111, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("rand%0d", i), $urandom, 4'($urandom), (i % 3 == 0));
    end

    // Reset during division must clear everything at once.
    applyStimulus("prereset", {8'd40, 8'd50, 8'd60, 8'd70}, 4'b1111, 0);
    @(negedge clk);
    data4  = {8'd23, 8'd22, 8'd21, 8'd20};
    en4    = 4'b1111;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst valid", valid4, 0);
    checkOutput("midrst busy", busy4, 0);
    checkOutput("midrst Q", q4, 0);
    checkOutput("midrst R", r4, 0);
    checkOutput("midrst nr", nr4, 0);
    checkOutput("midrst no_sensor", noSensor4, 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (valid4 || busy4) extra++;
    end
    checkOutput("midrst no valid", extra, 0);
    applyStimulus("postreset", {8'd0, 8'd25, 8'd0, 8'd30}, 4'b0101, 0);

    // Full-scale 100-sensor run and randomized wide runs.
    applyStimulus100("full100", {800{1'b1}}, {100{1'b1}});
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 25; k++) bigData[k*32 +: 32] = $urandom;
      bigEn = 100'({$urandom, $urandom, $urandom, $urandom});
      applyStimulus100($sformatf("rand100_%0d", i), bigData, bigEn);
    end
    applyStimulus100("none100", bigData, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
